// File: rtl/min_max_array_loader.sv
// Batch loader feeding a min/max finder: fills a 16-entry array over valid/ready,
// pulses Start, then captures the finder's result (or a watchdog error) until acknowledged.
module min_max_array_loader #(
  parameter int N_ELEM  = 16,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Start,
  input  logic              Finder_Done,
  input  logic [DATA_W-1:0] Max_In,
  input  logic [DATA_W-1:0] Min_In,
  output logic              Res_Valid,
  output logic [DATA_W-1:0] Res_Max,
  output logic [DATA_W-1:0] Res_Min,
  output logic              Res_Err,
  input  logic              Res_Ack,
  output logic [ADDR_W:0]   Count,
  output logic              Qi,
  output logic              Qf,
  output logic              Qs,
  output logic              Qw,
  output logic              Qr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [4:0] {
    S_INI  = 5'b00001,
    S_FILL = 5'b00010,
    S_STRT = 5'b00100,
    S_WAIT = 5'b01000,
    S_RSLT = 5'b10000
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [N_ELEM];
  logic [ADDR_W-1:0] wr_ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic              xfer;
  logic              wd_exp;

  assign xfer   = (state == S_FILL) && In_Valid;
  assign wd_exp = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INI:  state_nx = S_FILL;
      S_FILL: if (xfer && (wr_ptr == ADDR_W'(N_ELEM - 1))) state_nx = S_STRT;
      S_STRT: state_nx = S_WAIT;
      S_WAIT: if (Finder_Done || wd_exp) state_nx = S_RSLT;
      S_RSLT: if (Res_Ack) state_nx = S_INI;
      default: state_nx = S_INI;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_INI;
      wr_ptr  <= '0;
      Count   <= '0;
      wd_cnt  <= '0;
      Res_Max <= '0;
      Res_Min <= '0;
      Res_Err <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_INI: begin
          wr_ptr <= '0;
          Count  <= '0;
          wd_cnt <= '0;
        end
        S_FILL: if (xfer) begin
          wr_ptr <= wr_ptr + 1'b1;
          Count  <= Count + 1'b1;
        end
        S_STRT: wd_cnt <= '0;
        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A done indication on the expiry cycle still counts as a real result
          if (Finder_Done) begin
            Res_Max <= Max_In;
            Res_Min <= Min_In;
            Res_Err <= 1'b0;
          end else if (wd_exp) begin
            Res_Max <= '0;
            Res_Min <= '0;
            Res_Err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately unreset; only the write is gated by Reset
  always_ff @(posedge Clk) begin
    if (!Reset && xfer) mem[wr_ptr] <= In_Data;
  end

  assign Rd_Data   = mem[Rd_Addr];

  assign Qi        = (state == S_INI);
  assign Qf        = (state == S_FILL);
  assign Qs        = (state == S_STRT);
  assign Qw        = (state == S_WAIT);
  assign Qr        = (state == S_RSLT);

  assign In_Ready  = Qf;
  assign Start     = Qs;
  assign Res_Valid = Qr;

endmodule

// File: tb/tb_min_max_array_loader.sv
// Scoreboard bench for min_max_array_loader; the bench also plays the finder by scanning Rd_Addr.
module tb_min_max_array_loader;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 64;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          In_Valid = 1'b0;
  logic [DW-1:0] In_Data = '0;
  logic          In_Ready;
  logic [AW-1:0] Rd_Addr = '0;
  logic [DW-1:0] Rd_Data;
  logic          Start;
  logic          Finder_Done = 1'b0;
  logic [DW-1:0] Max_In = '0;
  logic [DW-1:0] Min_In = '0;
  logic          Res_Valid;
  logic [DW-1:0] Res_Max;
  logic [DW-1:0] Res_Min;
  logic          Res_Err;
  logic          Res_Ack = 1'b0;
  logic [AW:0]   Count;
  logic          Qi, Qf, Qs, Qw, Qr;

  min_max_array_loader #(
    .N_ELEM (N),
    .DATA_W (DW),
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_Valid   (In_Valid),
    .In_Data    (In_Data),
    .In_Ready   (In_Ready),
    .Rd_Addr    (Rd_Addr),
    .Rd_Data    (Rd_Data),
    .Start      (Start),
    .Finder_Done(Finder_Done),
    .Max_In     (Max_In),
    .Min_In     (Min_In),
    .Res_Valid  (Res_Valid),
    .Res_Max    (Res_Max),
    .Res_Min    (Res_Min),
    .Res_Err    (Res_Err),
    .Res_Ack    (Res_Ack),
    .Count      (Count),
    .Qi         (Qi),
    .Qf         (Qf),
    .Qs         (Qs),
    .Qw         (Qw),
    .Qr         (Qr)
  );

  always #20 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic          err;
  } res_t;

  res_t          sb[$];
  logic [DW-1:0] data [N];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model();
    res_t r;
    r.mx  = data[0];
    r.mn  = data[0];
    r.err = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (data[i] > r.mx) r.mx = data[i];
      if (data[i] < r.mn) r.mn = data[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_qi", Qi, 1);
    chk("rst_ready", In_Ready, 0);
    chk("rst_start", Start, 0);
    chk("rst_valid", Res_Valid, 0);
    chk("rst_count", Count, 0);
    chk("rst_err", Res_Err, 0);
    chk("rst_max", Res_Max, 0);
    chk("rst_min", Res_Min, 0);
  endtask

  // Streams data[0..n-1]; gap>0 drops In_Valid for gap cycles after each transfer
  // while waving Res_Ack/Finder_Done, which FILL must ignore.
  task automatic feed(input int n, input int gap);
    int         idx = 0;
    int         guard = 0;
    int         rdy = 0;
    int         gl = 0;
    logic       x;
    logic [AW:0] pc;
    In_Valid = 1'b1;
    In_Data  = data[0];
    while (idx < n && guard < 1000) begin
      if (In_Ready) rdy++;
      x  = In_Ready & In_Valid;
      pc = Count;
      tick();
      guard++;
      Res_Ack     = 1'b0;
      Finder_Done = 1'b0;
      if (x) begin
        idx++;
        chk("count_step", Count, idx);
        if (idx < n) begin
          if (gap > 0) begin
            In_Valid = 1'b0;
            gl = gap;
          end else begin
            In_Data = data[idx];
          end
        end
      end else begin
        chk("count_hold", Count, pc);
        if (!In_Valid) begin
          chk("fill_ignore", Qf, 1);
          gl--;
          if (gl == 0) begin
            In_Valid = 1'b1;
            In_Data  = data[idx];
          end
        end
      end
      if (!In_Valid && gl > 0) begin
        Res_Ack     = 1'b1;
        Finder_Done = 1'b1;
      end
    end
    In_Valid = 1'b0;
    if (idx < n) chk("feed_timeout", idx, n);
    if (n == N) begin
      chk("start_pulse", Start, 1);
      chk("state_strt", Qs, 1);
      chk("count16", Count, 16);
      if (gap == 0) chk("ready_cycles", rdy, N);
      Rd_Addr = 4'd5;
      #1;
      chk("rd_addr5", Rd_Data, data[5]);
    end
  endtask

  // respond=1: act as the finder after 'delay' WAIT cycles; respond=0: never finish.
  task automatic finder(input int delay, input bit respond);
    int            waitc = 0;
    int            guard = 0;
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    tick();
    chk("start_once", Start, 0);
    chk("state_wait", Qw, 1);
    if (respond) begin
      repeat (delay) tick();
      chk("wait_hold", Qw, 1);
      mx = '0;
      mn = '1;
      for (int a = 0; a < N; a++) begin
        Rd_Addr = a[AW-1:0];
        #1;
        chk("rd_scan", Rd_Data, data[a]);
        if (Rd_Data > mx) mx = Rd_Data;
        if (Rd_Data < mn) mn = Rd_Data;
      end
      Max_In      = mx;
      Min_In      = mn;
      Finder_Done = 1'b1;
      tick();
      Finder_Done = 1'b0;
      Max_In      = 8'hA5;
      Min_In      = 8'h5A;
    end else begin
      while (!Res_Valid && guard < 200) begin
        if (Qw) waitc++;
        Res_Ack = (guard == 1);
        tick();
        guard++;
        Res_Ack = 1'b0;
        if (guard == 2) chk("ack_in_wait", Qw, 1);
      end
      chk("wait_cycles", waitc, TO);
    end
    chk("res_valid", Res_Valid, 1);
    chk("state_rslt", Qr, 1);
  endtask

  task automatic check_result();
    res_t e;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_max", Res_Max, e.mx);
      chk("res_min", Res_Min, e.mn);
      chk("res_err", Res_Err, e.err);
      repeat (3) begin
        tick();
        chk("valid_hold", Res_Valid, 1);
        chk("max_hold", Res_Max, e.mx);
      end
      Res_Ack = 1'b1;
      tick();
      Res_Ack = 1'b0;
      chk("ack_ini", Qi, 1);
      chk("valid_drop", Res_Valid, 0);
      chk("max_keep", Res_Max, e.mx);
      chk("err_keep", Res_Err, e.err);
      tick();
      chk("ack_fill", In_Ready, 1);
    end
  endtask

  initial begin
    res_t r;

    do_reset();

    for (int i = 0; i < N; i++) data[i] = 8'(8'h10 + i);
    sb.push_back(model());
    feed(N, 0);
    finder(0, 1);
    check_result();

    data = '{8'h80, 8'h03, 8'hFE, 8'h21, 8'h57, 8'h9A, 8'hC3, 8'h44,
             8'h12, 8'hEE, 8'h7F, 8'h05, 8'hB0, 8'h66, 8'h39, 8'h41};
    sb.push_back(model());
    feed(N, 0);
    finder(0, 1);
    check_result();

    // Bursty input; finder answers on the same cycle the watchdog expires
    for (int i = 0; i < N; i++) data[i] = 8'($urandom);
    sb.push_back(model());
    feed(N, 2);
    finder(TO - 1, 1);
    check_result();

    for (int i = 0; i < N; i++) data[i] = 8'($urandom);
    r = '{mx: 8'h00, mn: 8'h00, err: 1'b1};
    sb.push_back(r);
    feed(N, 0);
    finder(0, 0);
    check_result();

    // Partial batch aborted by reset, with a transfer offered on the reset edge
    for (int i = 0; i < N; i++) data[i] = 8'hF0 | 8'(i);
    feed(7, 0);
    In_Valid = 1'b1;
    In_Data  = data[7];
    Reset    = 1'b1;
    tick();
    Reset    = 1'b0;
    In_Valid = 1'b0;
    chk("midrst_qi", Qi, 1);
    chk("midrst_count", Count, 0);
    chk("midrst_err", Res_Err, 0);
    chk("midrst_ready", In_Ready, 0);
    for (int i = 0; i < N; i++) data[i] = 8'(8'h20 + 3 * i);
    sb.push_back(model());
    feed(N, 1);
    finder(5, 1);
    check_result();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/min_max_array_loader.md
Name: min_max_array_loader

Overview:
- Upstream feeder for the min/max finder.
- Accepts a stream of 8-bit unsigned values over a valid/ready handshake and fills a 16-entry array.
- Exposes the array through an asynchronous read port, pulses Start to the finder, waits for the finder's done state, then captures Max/Min into a held result register until acknowledged.
- Includes a watchdog so a hung finder cannot stall the batch.

Parameters:
- N_ELEM, 16, number of array entries per batch; power of 2.
- DATA_W, 8, element width, unsigned.
- ADDR_W, 4, log2(N_ELEM).
- TIMEOUT, 64, maximum cycles spent in WAIT before the error exit; counter width $clog2(TIMEOUT+1).

Ports:
- Clk  in  1  rising-edge clock; single clock domain.
- Reset  in  1  synchronous, active-high; sampled on posedge Clk only.
- In_Valid  in  1  producer has In_Data valid.
- In_Data  in  DATA_W  element to store.
- In_Ready  out  ADDR_W-independent 1  loader accepts an element this cycle.
- Rd_Addr  in  ADDR_W  finder's read index I.
- Rd_Data  out  DATA_W  M[Rd_Addr], combinational.
- Start  out  1  one-cycle pulse to the finder.
- Finder_Done  in  1  finder's Qd (done-state) output.
- Max_In  in  DATA_W  finder's Max.
- Min_In  in  DATA_W  finder's Min.
- Res_Valid  out  1  result registers hold a completed batch.
- Res_Max  out  DATA_W  captured maximum.
- Res_Min  out  DATA_W  captured minimum.
- Res_Err  out  1  batch ended by watchdog timeout.
- Res_Ack  in  1  consumer accepts the result.
- Count  out  ADDR_W+1  elements written in the current batch, 0..16.
- Qi, Qf, Qs, Qw, Qr  out  1 each  one-hot state bits: INI, FILL, STRT, WAIT, RSLT.

Behaviour:
- State register is one-hot, 5 bits.
- All registered outputs are Moore: In_Ready = Qf, Start = Qs, Res_Valid = Qr.
- Reset (sync):
  - state = INI; Wr_Ptr = 0; Count = 0; Wd_Cnt = 0.
  - Res_Max = 0; Res_Min = 0; Res_Err = 0.
  - Outputs after reset: In_Ready 0, Start 0, Res_Valid 0.
  - Array contents are not reset.
- INI:
  - Clear Wr_Ptr, Count and Wd_Cnt.
  - Go to FILL unconditionally next clock.
- FILL:
  - In_Ready = 1.
  - A transfer occurs on a clock edge where In_Valid && In_Ready: M[Wr_Ptr] <= In_Data, Wr_Ptr <= Wr_Ptr+1, Count <= Count+1.
  - The transfer with Wr_Ptr == N_ELEM-1 moves the state to STRT; Wr_Ptr wraps to 0 and Count becomes 16.
  - With no In_Valid, the block stays in FILL indefinitely.
- STRT:
  - Start = 1 for exactly one cycle; clear Wd_Cnt; go to WAIT.
- WAIT:
  - Start = 0; Wd_Cnt increments every cycle.
  - If Finder_Done = 1 at the edge: Res_Max <= Max_In, Res_Min <= Min_In, Res_Err <= 0, go to RSLT.
  - Else if Wd_Cnt == TIMEOUT-1: Res_Max <= 0, Res_Min <= 0, Res_Err <= 1, go to RSLT.
  - If both conditions hold in the same cycle, Finder_Done wins.
- RSLT:
  - Res_Valid = 1; Res_Max, Res_Min and Res_Err are held stable.
  - Res_Ack = 1 at the edge returns the state to INI; Res_Valid drops the next cycle.
  - Res_Err keeps its value until the next capture.
- Array stability:
  - Array writes occur only in FILL, so M is stable through STRT, WAIT and RSLT.
  - Rd_Data reflects M[Rd_Addr] combinationally in every state.
  - A read of the address being written in the same cycle returns the old value.
- Ignored inputs:
  - In_Valid outside FILL is ignored; no write occurs and the producer holds its data.
  - Finder_Done outside WAIT is ignored.
  - Res_Ack outside RSLT is ignored.
- Reset mid-operation: next state is INI; any partial batch is discarded and the result registers are cleared. Reset has priority over every other event in the same cycle.
- Latency:
  - Last accepted element to Start pulse: 1 cycle.
  - Finder_Done seen to Res_Valid = 1: 1 cycle.
  - Total from reset to first In_Ready = 1: 2 cycles (the INI cycle plus the first FILL cycle).

Test Plan:
- Reset, then stream 16 values 0x10..0x1F with In_Valid held high (0x10 first) -> In_Ready high 16 cycles; Start pulses exactly 1 cycle after the last transfer; Rd_Data at addr 5 = 0x15; Count = 16.
- Stream {0x80, 0x03, 0xFE, ..., 0x41} to a finder connected to this block -> Res_Max = 0xFE, Res_Min = 0x03, Res_Err = 0, Res_Valid held until Res_Ack.
- Bursty In_Valid (1 cycle on, 2 cycles off) -> exactly 16 writes, no duplicates, Start fires once; Count steps 0..16 only on handshake cycles.
- Finder_Done tied to 0 -> after Start, WAIT lasts exactly TIMEOUT=64 cycles; then Res_Err = 1, Res_Max = Res_Min = 0x00, Res_Valid = 1.
- Assert Reset after 7 elements are written -> next cycle state INI, Count 0; a new 16-element batch produces correct results and none of the old data leaks through.
- Res_Ack pulsed during FILL and WAIT -> ignored. In RSLT, Res_Ack -> INI, then FILL two cycles later; Res_Max holds its old value until the next capture.
